// File: rtl/palette_fade_lut.sv
// Run-time writable multi-palette RGB565 lookup with a two-stage pipeline and a
// frame-synchronised fade-to/from-black brightness engine.
module palette_fade_lut #(
    parameter int INDEX_W  = 3,
    parameter int NUM_PAL  = 4,
    parameter int FADE_DIV = 4,
    parameter int PAL_W    = $clog2(NUM_PAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic [INDEX_W-1:0] pix_index,
    input  logic [PAL_W-1:0]   pix_pal,
    input  logic               wr_en,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [15:0]        wr_data,
    input  logic               frame_tick,
    input  logic               fade_out_start,
    input  logic               fade_in_start,
    output logic               out_valid,
    output logic [15:0]        out_rgb,
    output logic               out_transparent,
    output logic [3:0]         fade_level,
    output logic               fade_busy,
    output logic               fade_done
);

    localparam int ADDR_W  = PAL_W + INDEX_W;
    localparam int NUM_ENT = 1 << ADDR_W;
    localparam int CNT_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

    fade_state_t        state, state_nxt;
    logic [3:0]         level_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               done_nxt;
    logic [15:0]        pal [NUM_ENT];
    logic               vld_p1;
    logic [15:0]        rgb_p1;
    logic               transp_p1;

    function automatic logic [15:0] default_entry(input logic [2:0] i);
        case (i)
            3'd0:    return 16'h0E3B;
            3'd1:    return 16'h0000;
            3'd2:    return 16'hFFDF;
            3'd3:    return 16'hA244;
            3'd4:    return 16'h6160;
            3'd5:    return 16'hFFC0;
            3'd6:    return 16'hEAE2;
            default: return 16'h0E3B;
        endcase
    endfunction

    // Per-channel c * (8 - L) >> 3 with floor; the weight never exceeds 8 so the
    // shifted product always fits back into the channel width.
    function automatic logic [15:0] scale_rgb565(input logic [15:0] c, input logic [3:0] lvl);
        logic [3:0] w;
        w = 4'd8 - lvl;
        return {5'(({4'b0, c[15:11]} * {5'b0, w}) >> 3),
                6'(({4'b0, c[10:5]}  * {6'b0, w}) >> 3),
                5'(({4'b0, c[4:0]}   * {5'b0, w}) >> 3)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                pal[i] <= default_entry(i[2:0]);
            end
        end else if (wr_en) begin
            pal[{wr_pal, wr_idx}] <= wr_data;
        end
    end

    // Stage 1: palette read (sees pre-write contents on a same-cycle write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            rgb_p1    <= pal[{pix_pal, pix_index}];
            transp_p1 <= (pix_index == '0);
        end
    end

    // Stage 2: brightness scaling with the level current at this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_rgb         <= 16'h0000;
            out_transparent <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_rgb         <= scale_rgb565(rgb_p1, fade_level);
                out_transparent <= transp_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fade_level <= 4'd0;
            cnt        <= '0;
            fade_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            fade_level <= level_nxt;
            cnt        <= cnt_nxt;
            fade_done  <= done_nxt;
        end
    end

    // A start pulse always restarts from the current level; fade_in wins a tie.
    always_comb begin
        state_nxt = state;
        level_nxt = fade_level;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (fade_in_start) begin
            if (fade_level == 4'd0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = FADE_IN;
                cnt_nxt   = '0;
            end
        end else if (fade_out_start) begin
            if (fade_level == 4'd8) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = FADE_OUT;
                cnt_nxt   = '0;
            end
        end else if (state != IDLE && frame_tick) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                level_nxt = (state == FADE_OUT) ? fade_level + 4'd1 : fade_level - 4'd1;
                if (level_nxt == ((state == FADE_OUT) ? 4'd8 : 4'd0)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    assign fade_busy = (state != IDLE);

endmodule
